usb_fs_out_rxbuf: RTL

Endpoint-side consumer of the full-speed USB receive path. Watches decoded token and data packets in the `clk` domain, matches OUT tokens for one endpoint, and writes DATA0/DATA1 payload bytes speculatively into a byte FIFO. It commits the payload (with the trailing CRC16 bytes stripped) only when the packet passes its checks and the toggle is correct; otherwise it rolls back. It also requests the ACK or NAK handshake for the transmit path and presents committed bytes to the CPU side with show-ahead semantics.

---
 rtl/usb_fs_out_rxbuf.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/usb_fs_out_rxbuf.sv
// rtl/usb_fs_out_rxbuf.sv - OUT endpoint receive buffer with speculative commit and ACK/NAK request
//
// Matches OUT tokens addressed to (dev_addr, ENDP). Writes the following DATA0/DATA1
// bytes speculatively into a byte FIFO. Commits them minus the CRC16 trailer only when
// the packet is good and carries the expected toggle. Otherwise the bytes are rolled back.
//
// Ports:
//   clk, reset            endpoint clock, synchronous active-high reset
//   dev_addr              current device address
//   rx_pkt_start/end      packet framing pulses from the receive path
//   rx_pid/addr/endp      decoded fields, valid with rx_pkt_end
//   rx_pkt_valid          packet passed PID/CRC checks (sampled on rx_pkt_end)
//   rx_data_put, rx_data  received byte stream (payload then CRC lo, hi)
//   hs_req, hs_pid        registered handshake request (ACK/NAK) for the transmit path
//   data_avail, data_out  show-ahead head of the committed FIFO
//   data_get              pop head byte
//   data_count            committed bytes in the FIFO
module usb_fs_out_rxbuf #(
    parameter int DEPTH_LOG2 = 6,
    parameter int ENDP       = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            dev_addr,
    input  logic                  rx_pkt_start,
    input  logic                  rx_pkt_end,
    input  logic [3:0]            rx_pid,
    input  logic [6:0]            rx_addr,
    input  logic [3:0]            rx_endp,
    input  logic                  rx_pkt_valid,
    input  logic                  rx_data_put,
    input  logic [7:0]            rx_data,
    output logic                  hs_req,
    output logic [3:0]            hs_pid,
    output logic                  data_avail,
    output logic [7:0]            data_out,
    input  logic                  data_get,
    output logic [DEPTH_LOG2:0]   data_count
);

    localparam int PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TOKEN,
        S_DATA
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   spec_ptr_q, spec_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            toggle_q, toggle_d;
    logic            ovf_q, ovf_d;
    // Only "fewer than two bytes" matters at packet end, so a 2-bit saturating count suffices.
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic            hs_req_q, hs_req_d;
    logic [3:0]      hs_pid_q, hs_pid_d;
    logic            mem_we;
    logic [PW-1:0]   spec_used;
    logic            is_data_pid;

    logic [7:0] mem [2**DEPTH_LOG2];

    // Occupancy seen by the speculative writer; uses the live read pointer so pops
    // during a packet free space immediately.
    assign spec_used   = spec_ptr_q - rd_ptr_q;
    assign is_data_pid = (rx_pid == PID_DATA0) || (rx_pid == PID_DATA1);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        spec_ptr_d = spec_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        toggle_d   = toggle_q;
        ovf_d      = ovf_q;
        byte_cnt_d = byte_cnt_q;
        hs_req_d   = 1'b0;
        hs_pid_d   = hs_pid_q;
        mem_we     = 1'b0;

        if (data_get && (wr_ptr_q != rd_ptr_q)) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (rx_pkt_end && rx_pkt_valid && (rx_pid == PID_OUT) &&
                    (rx_addr == dev_addr) && (rx_endp == 4'(ENDP))) begin
                    state_d = S_TOKEN;
                end
            end
            S_TOKEN: begin
                if (rx_pkt_start) begin
                    state_d    = S_DATA;
                    spec_ptr_d = wr_ptr_q;
                    byte_cnt_d = 2'd0;
                    ovf_d      = 1'b0;
                end else if (rx_pkt_end) begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (rx_pkt_end) begin
                    state_d = S_IDLE;
                    if (!rx_pkt_valid || !is_data_pid || (byte_cnt_q < 2'd2)) begin
                        // silently dropped: host will time out and retry
                    end else if (ovf_q) begin
                        hs_req_d = 1'b1;
                        hs_pid_d = PID_NAK;
                    end else if (rx_pid[3] == toggle_q) begin
                        wr_ptr_d = spec_ptr_q - PW'(2);
                        toggle_d = ~toggle_q;
                        hs_req_d = 1'b1;
                        hs_pid_d = PID_ACK;
                    end else begin
                        // duplicate of an already-accepted packet: our ACK was lost
                        hs_req_d = 1'b1;
                        hs_pid_d = PID_ACK;
                    end
                end else if (rx_pkt_start) begin
                    spec_ptr_d = wr_ptr_q;
                    byte_cnt_d = 2'd0;
                    ovf_d      = 1'b0;
                end else if (rx_data_put) begin
                    if (byte_cnt_q != 2'd3) begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                    if (spec_used < DEPTH) begin
                        mem_we     = 1'b1;
                        spec_ptr_d = spec_ptr_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            spec_ptr_q <= '0;
            rd_ptr_q   <= '0;
            toggle_q   <= 1'b0;
            ovf_q      <= 1'b0;
            byte_cnt_q <= 2'd0;
            hs_req_q   <= 1'b0;
            hs_pid_q   <= 4'd0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            spec_ptr_q <= spec_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            toggle_q   <= toggle_d;
            ovf_q      <= ovf_d;
            byte_cnt_q <= byte_cnt_d;
            hs_req_q   <= hs_req_d;
            hs_pid_q   <= hs_pid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[spec_ptr_q[DEPTH_LOG2-1:0]] <= rx_data;
        end
    end

    assign hs_req     = hs_req_q;
    assign hs_pid     = hs_pid_q;
    assign data_avail = (wr_ptr_q != rd_ptr_q);
    assign data_count = wr_ptr_q - rd_ptr_q;
    assign data_out   = mem[rd_ptr_q[DEPTH_LOG2-1:0]];

endmodule
